// File: rtl/lcd_frame_ctrl.sv
// lcd_frame_ctrl: frame-content controller for the 24x3 multiplexed LCD driver.
//
// Two requesters write 3-bit segment groups into a shadow frame through a
// round-robin arbiter. A commit pulse copies the whole shadow frame into the
// active frame in one cycle, so the display never shows a half-written frame.
// Groups can be set to blink. segout feeds the driver's segin input.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_x/idx_x/dat_x      write request, group index and group data (x = a, b)
//   gnt_x                  one-cycle grant; the write lands on the same edge
//   blink_we/idx/en        blink-mask write (takes effect without commit)
//   commit                 one-cycle pulse: copy shadow to active
//   busy                   high while the copy cycle is in progress
//   err                    pulses together with gnt when idx >= NGRP
//   segout[3j+2:3j]        registered output for group j
module lcd_frame_ctrl #(
  parameter int Fclk     = 8000,
  parameter int BLINK_MS = 500,
  parameter int NGRP     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [4:0]        idx_a,
  input  logic [2:0]        dat_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [4:0]        idx_b,
  input  logic [2:0]        dat_b,
  output logic              gnt_b,
  input  logic              blink_we,
  input  logic [4:0]        blink_idx,
  input  logic              blink_en,
  input  logic              commit,
  output logic              busy,
  output logic              err,
  output logic [NGRP*3-1:0] segout
);

  localparam int MS_W = (Fclk > 1) ? $clog2(Fclk) : 1;
  localparam int TK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [MS_W-1:0] MS_MAX = MS_W'(Fclk - 1);
  localparam logic [TK_W-1:0] TK_MAX = TK_W'(BLINK_MS - 1);
  localparam logic [5:0] NGRP_L = 6'(NGRP);

  typedef enum logic {IDLE, COPY} state_t;

  state_t state, state_nx;
  logic   pend, pend_nx;

  logic [2:0]      shadow [NGRP];
  logic [2:0]      active [NGRP];
  logic [NGRP-1:0] blink_mask;

  logic [MS_W-1:0] ms_cnt;
  logic [TK_W-1:0] tick_cnt;
  logic            phase;

  logic            last_a;
  logic            elig_a, elig_b, sel_a, sel_b, w_en, w_ok;
  logic [4:0]      w_idx;
  logic [2:0]      w_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
    end
  end

  // A commit arriving while the copy is running is remembered and replayed
  // after one IDLE cycle, so the latest shadow contents always reach active.
  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    case (state)
      IDLE: begin
        if (commit || pend) begin
          state_nx = COPY;
          pend_nx  = 1'b0;
        end
      end
      COPY: begin
        state_nx = IDLE;
        if (commit) pend_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == COPY);

  // A port whose grant is showing this cycle still has its old request up,
  // so it is not eligible again until the following cycle.
  always_comb begin
    elig_a = req_a && !gnt_a && (state == IDLE);
    elig_b = req_b && !gnt_b && (state == IDLE);
    sel_a  = elig_a && (!elig_b || !last_a);
    sel_b  = elig_b && !sel_a;
    w_en   = sel_a || sel_b;
    w_idx  = sel_a ? idx_a : idx_b;
    w_dat  = sel_a ? dat_a : dat_b;
    w_ok   = ({1'b0, w_idx} < NGRP_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      err    <= 1'b0;
      last_a <= 1'b0;
      for (int j = 0; j < NGRP; j++) shadow[j] <= 3'b000;
    end else begin
      gnt_a <= sel_a;
      gnt_b <= sel_b;
      err   <= w_en && !w_ok;
      if (w_en) last_a <= sel_a;
      if (w_en && w_ok) shadow[w_idx] <= w_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NGRP; j++) active[j] <= 3'b000;
    end else if (state == COPY) begin
      active <= shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_mask <= '0;
    end else if (blink_we && ({1'b0, blink_idx} < NGRP_L)) begin
      blink_mask[blink_idx] <= blink_en;
    end
  end

  // Free-running 1 ms tick and blink half-period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_cnt   <= '0;
      tick_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      if (ms_cnt == MS_MAX) begin
        ms_cnt <= '0;
        if (tick_cnt == TK_MAX) begin
          tick_cnt <= '0;
          phase    <= !phase;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end else begin
        ms_cnt <= ms_cnt + 1'b1;
      end
    end
  end

  // Output register: blanked groups drive all commons off.
  always_ff @(posedge clk) begin
    if (rst) begin
      segout <= '0;
    end else begin
      for (int j = 0; j < NGRP; j++)
        segout[3*j +: 3] <= (blink_mask[j] && phase) ? 3'b000 : active[j];
    end
  end

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
module tb_lcd_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, blink_we, blink_en, commit;
  logic [4:0]  idx_a, idx_b, blink_idx;
  logic [2:0]  dat_a, dat_b;
  logic        gnt_a, gnt_b, busy, err;
  logic [71:0] segout;

  int nchecks = 0;
  int nfail   = 0;

  lcd_frame_ctrl #(.Fclk(4), .BLINK_MS(2), .NGRP(24)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .idx_a(idx_a), .dat_a(dat_a), .gnt_a(gnt_a),
    .req_b(req_b), .idx_b(idx_b), .dat_b(dat_b), .gnt_b(gnt_b),
    .blink_we(blink_we), .blink_idx(blink_idx), .blink_en(blink_en),
    .commit(commit), .busy(busy), .err(err), .segout(segout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    nchecks++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    nchecks++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Commit pulse at t; returns in cycle t+3 when segout shows the new frame.
  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
    step();
    step();
  endtask

  initial begin
    int   seen, bad, nchg, last_t, cyc;
    logic [2:0] prev, cur;

    rst = 1'b1;
    req_a = 0; req_b = 0; idx_a = 0; idx_b = 0; dat_a = 0; dat_b = 0;
    blink_we = 0; blink_idx = 0; blink_en = 0; commit = 0;
    step();
    step();
    rst = 1'b0;

    // Idle after reset
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gnt_a || gnt_b || err || busy) seen++;
    end
    chki("idle_ctrl", seen, 0);
    chks("idle_segout", segout, 72'h0);

    // Single write from A, then commit with latency checks
    req_a = 1; idx_a = 5'd0; dat_a = 3'b101;
    step();
    chkb("w1_gnt_a", gnt_a, 1'b1);
    chkb("w1_gnt_b", gnt_b, 1'b0);
    chkb("w1_err", err, 1'b0);
    step();
    chkb("w1_gnt_a_once", gnt_a, 1'b0);
    req_a = 0;
    commit = 1;
    step();
    commit = 0;
    chkb("c1_busy_t1", busy, 1'b1);
    step();
    chkb("c1_busy_t2", busy, 1'b0);
    chks("c1_segout_t2", segout, 72'h0);
    step();
    chks("c1_segout_t3", segout, 72'h5);

    // Reset clears the displayed frame and arbiter history
    rst = 1;
    step();
    rst = 0;
    chks("rst_segout", segout, 72'h0);
    chkb("rst_busy", busy, 1'b0);

    // Both ports requesting: A, B, A
    req_a = 1; idx_a = 5'd1; dat_a = 3'b111;
    req_b = 1; idx_b = 5'd2; dat_b = 3'b111;
    step();
    chkb("rr1_gnt_a", gnt_a, 1'b1);
    chkb("rr1_gnt_b", gnt_b, 1'b0);
    step();
    chkb("rr2_gnt_a", gnt_a, 1'b0);
    chkb("rr2_gnt_b", gnt_b, 1'b1);
    step();
    chkb("rr3_gnt_a", gnt_a, 1'b1);
    chkb("rr3_gnt_b", gnt_b, 1'b0);
    req_a = 0; req_b = 0;
    step();
    chkb("rr4_gnt_a", gnt_a, 1'b0);
    chkb("rr4_gnt_b", gnt_b, 1'b0);
    do_commit();
    chks("rr_segout", segout, 72'h1F8);

    // Out-of-range index: granted, flagged, dropped
    req_b = 1; idx_b = 5'd27; dat_b = 3'b111;
    step();
    chkb("oor_gnt_b", gnt_b, 1'b1);
    chkb("oor_err", err, 1'b1);
    step();
    chkb("oor_err_pulse", err, 1'b0);
    req_b = 0;
    do_commit();
    chks("oor_segout", segout, 72'h1F8);

    // Commit during COPY, with writes landing in each copy
    commit = 1; req_a = 1; idx_a = 5'd3; dat_a = 3'b010;
    step();
    chkb("cc_busy_t1", busy, 1'b1);
    chkb("cc_gnt_a", gnt_a, 1'b1);
    step();
    commit = 0; req_a = 0;
    chkb("cc_busy_t2", busy, 1'b0);
    req_b = 1; idx_b = 5'd4; dat_b = 3'b001;
    step();
    chkb("cc_busy_t3", busy, 1'b1);
    chkb("cc_gnt_b", gnt_b, 1'b1);
    chks("cc_segout_t3", segout, 72'h5F8);
    step();
    req_b = 0;
    chkb("cc_busy_t4", busy, 1'b0);
    chks("cc_segout_t4", segout, 72'h5F8);
    step();
    chks("cc_segout_t5", segout, 72'h15F8);

    // Blink on group 0
    req_a = 1; idx_a = 5'd0; dat_a = 3'b111;
    step();
    step();
    req_a = 0;
    do_commit();
    chks("bl_base", segout, 72'h15FF);
    blink_we = 1; blink_idx = 5'd0; blink_en = 1;
    step();
    blink_we = 0;
    nchg = 0; last_t = 0; bad = 0;
    prev = segout[2:0];
    for (cyc = 1; cyc <= 40; cyc++) begin
      step();
      cur = segout[2:0];
      if (segout[71:3] !== 69'h2BF) bad++;
      if (cur !== prev) begin
        chkb("bl_val", (cur === 3'b000) || (cur === 3'b111), 1'b1);
        nchg++;
        if (nchg > 1) chki("bl_period", cyc - last_t, 8);
        last_t = cyc;
      end
      prev = cur;
    end
    chkb("bl_toggles", nchg >= 4, 1'b1);
    chki("bl_others", bad, 0);

    // Blink off: steady
    blink_we = 1; blink_idx = 5'd0; blink_en = 0;
    step();
    blink_we = 0;
    step();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (segout[2:0] !== 3'b111) bad++;
      step();
    end
    chki("bl_off_steady", bad, 0);

    // Reset in the middle of a copy
    commit = 1;
    step();
    commit = 0;
    chkb("rc_busy", busy, 1'b1);
    rst = 1;
    step();
    rst = 0;
    chkb("rc_busy_after", busy, 1'b0);
    step();
    step();
    chks("rc_segout", segout, 72'h0);

    $display("%0d/%0d checks passed", nchecks - nfail, nchecks);
    $finish;
  end

endmodule

// File: doc/lcd_frame_ctrl.md
Name: lcd_frame_ctrl

Overview:
- Frame-content controller in front of the 24x3 multiplexed LCD segment driver.
- Arbitrates 3-bit segment-group writes from two requesters (A: host/UI, B: status) into a shadow frame.
- Copies the shadow frame to the active frame atomically on commit, so the display never shows a partial update.
- Applies per-group blinking and drives the driver's 72-bit segment input.

Parameters:
- Fclk, 8000, system clock frequency in kHz; sets the 1 ms tick.
- BLINK_MS, 500, blink half-period in ms.
- NGRP, 24, number of 3-bit segment groups (one group per driver segment line).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_a  in  1  write request, port A; held high until granted.
- idx_a  in  5  group index, port A.
- dat_a  in  3  group data, port A (bit0=com0, bit1=com1, bit2=com2).
- gnt_a  out  1  one-cycle grant, port A.
- req_b  in  1  write request, port B.
- idx_b  in  5  group index, port B.
- dat_b  in  3  group data, port B.
- gnt_b  out  1  one-cycle grant, port B.
- blink_we  in  1  blink-mask write strobe.
- blink_idx  in  5  blink-mask group index.
- blink_en  in  1  blink-mask bit value.
- commit  in  1  one-cycle pulse: copy shadow to active.
- busy  out  1  high during the COPY state.
- err  out  1  one-cycle pulse: index >= NGRP was written (write dropped).
- segout  out  72  to driver segin; group j occupies bits [3j+2:3j].

Behaviour:
- Reset (synchronous, active-high):
  - shadow, active and blink_mask = 0.
  - segout = 0, gnt_a = gnt_b = err = busy = 0.
  - state = IDLE, pend = 0, blink phase = 0, tick counters = 0.
  - Reset asserted mid-COPY aborts the copy; active stays 0.
- State machine:
  - IDLE: arbitration enabled.
    - commit=1 or pend=1 -> COPY; pend cleared.
  - COPY (exactly 1 cycle): busy=1, no grants.
    - At the end of COPY: active <= shadow, then -> IDLE.
    - commit=1 during COPY sets pend, causing one more COPY after one IDLE cycle.
- Arbiter (round-robin):
  - Runs in IDLE only.
  - With one request, that port is granted. With both, the port not granted last wins; after reset, A has priority.
  - gnt is registered: gnt_x goes high in the cycle after the request is sampled and stays high for 1 cycle.
  - The shadow write occurs at the clock edge that ends the sampled cycle; the grant is its acknowledge.
  - A requester samples gnt, drops req in the cycle after gnt, or keeps it high to queue another write.
  - Back-to-back writes from one port are therefore at most one every 2 cycles. With both ports requesting, grants alternate A/B every cycle.
  - A write granted in the same cycle commit is sampled is included in that copy.
- Index range:
  - idx >= NGRP (24..31) is still granted; shadow is unchanged and err pulses in the same cycle as gnt.
  - blink_idx >= NGRP is ignored silently.
- Blink timing:
  - ms counter counts 0..Fclk-1; its wrap produces a 1 ms tick.
  - A tick counter counts 0..BLINK_MS-1; its wrap toggles phase.
  - Both counters free-run and are independent of commits.
- Blink mask:
  - blink_we writes blink_mask[blink_idx] = blink_en at the next edge.
  - The mask takes effect immediately; it does not wait for commit.
- Output: segout group j = active[j] when (blink_mask[j] & phase) = 0, otherwise 3'b000.
  - segout is registered: 1 cycle after active, mask or phase changes.
- Latency from commit pulse at cycle t:
  - busy=1 in t+1.
  - active is updated at the end of t+1.
  - segout shows the new frame in t+3; busy=0 in t+2.
- Simultaneous events:
  - commit with blink_we: both take effect.
  - Requests during COPY are held off without loss, because requesters keep req high until granted.

Test Plan:
- Reset, then idle 10 cycles -> segout=0, busy=0, no gnt/err.
- req_a with idx=0, dat=3'b101, then commit -> gnt_a for 1 cycle; segout[2:0]=3'b101 at commit+3; segout[71:3]=0.
- req_a and req_b held together, A to idx 1 and B to idx 2, both dat=3'b111 -> grants alternate A,B,A... starting with A; after commit, segout[5:3]=segout[8:6]=3'b111.
- req_b with idx=27 -> gnt_b and err in the same cycle; after commit, segout is unchanged.
- commit during COPY (commit pulses at t and t+1) -> busy high in t+1 and t+3, low in t+2; final active equals shadow.
- Fclk=4, BLINK_MS=2; group 0=3'b111 committed; blink_we idx=0, en=1 -> segout[2:0] toggles between 111 and 000 every 8 cycles; blink_en=0 -> segout[2:0] stays steady at 111.
